// File: rtl/config_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : config_loader_pkg
// Brief   : Shared state encoding and CRC-16-CCITT constants and step function
//           for the configuration chain loader.
// Revision: 1.0  initial release
// ============================================================================
package config_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] c_CRC_POLY = 16'h1021;
    localparam logic [15:0] c_CRC_INIT = 16'hFFFF;

    // One bit of an MSB-first, non-reflected CRC register.
    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic d);
        logic w_fb;
        w_fb = d ^ c[15];
        return {c[14:0], 1'b0} ^ (w_fb ? c_CRC_POLY : 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/config_loader_crc16_serial.sv
`default_nettype none
// ============================================================================
// Module  : crc16_serial
// Brief   : Bit-serial CRC-16-CCITT accumulator; clr re-seeds, en absorbs d.
// Revision: 1.0  initial release
// ============================================================================
module crc16_serial
    import config_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        d,
    output logic [15:0] crc
);

    logic [15:0] r_crc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= c_CRC_INIT;
        end else if (clr) begin
            r_crc <= c_CRC_INIT;
        end else if (en) begin
            r_crc <= crc16_step(r_crc, d);
        end
    end

    assign crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/config_loader.sv
`default_nettype none
// ============================================================================
// Module  : config_loader
// Brief   : Serialises host bytes LSB-first into the configuration scan chain
//           and optionally recirculates it once to verify a readback CRC.
// Revision: 1.0  initial release
// ============================================================================
module config_loader
    import config_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 80,
    parameter bit VERIFY    = 1'b1
) (
    input  logic        prog_clk,
    input  logic        prog_rst,
    input  logic        start,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        prog_data,
    output logic        prog_en,
    input  logic        prog_ret,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] crc
);

    localparam int              c_CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CHAIN_LEN - 1);

    state_t               r_state;
    state_t               w_next;
    logic [7:0]           r_buf;
    logic                 r_buf_valid;
    logic [2:0]           r_idx;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_start_acc;
    logic                 w_at_last;
    logic                 w_hs;
    logic                 w_ld_en;
    logic                 w_rb_en;
    logic [15:0]          w_crc_ld;
    logic [15:0]          w_crc_rb;

    assign w_start_acc = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_at_last   = (r_count == c_LAST);
    assign w_hs        = s_valid & s_ready;

    always_comb begin
        w_next    = r_state;
        s_ready   = 1'b0;
        prog_en   = 1'b0;
        prog_data = 1'b0;
        w_ld_en   = 1'b0;
        w_rb_en   = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_acc) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                prog_en   = r_buf_valid;
                prog_data = r_buf[0];
                w_ld_en   = r_buf_valid;
                // Refill during the final bit of a byte so bytes stream gap-free.
                s_ready   = ~r_buf_valid | (r_buf_valid & (r_idx == 3'd7) & ~w_at_last);
                if (r_buf_valid && w_at_last) w_next = VERIFY ? ST_CHECK : ST_DONE;
            end
            ST_CHECK: begin
                prog_en   = 1'b1;
                prog_data = prog_ret;
                w_rb_en   = 1'b1;
                if (w_at_last) w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (prog_rst) begin
            r_state     <= ST_IDLE;
            r_buf       <= '0;
            r_buf_valid <= 1'b0;
            r_idx       <= '0;
            r_count     <= '0;
        end else begin
            r_state <= w_next;
            if (w_start_acc) begin
                r_count     <= '0;
                r_buf_valid <= 1'b0;
            end else if (r_state == ST_LOAD) begin
                if (r_buf_valid) begin
                    r_buf <= {1'b0, r_buf[7:1]};
                    r_idx <= r_idx + 3'd1;
                    if (w_at_last) begin
                        r_count     <= '0;
                        r_buf_valid <= 1'b0;
                    end else begin
                        r_count <= r_count + c_CNT_W'(1);
                        if (r_idx == 3'd7) r_buf_valid <= 1'b0;
                    end
                end
                if (w_hs) begin
                    r_buf       <= s_data;
                    r_idx       <= '0;
                    r_buf_valid <= 1'b1;
                end
            end else if (r_state == ST_CHECK) begin
                r_count <= w_at_last ? '0 : r_count + c_CNT_W'(1);
            end
        end
    end

    crc16_serial u_crc_ld (
        .clk (prog_clk),
        .rst (prog_rst),
        .clr (w_start_acc),
        .en  (w_ld_en),
        .d   (prog_data),
        .crc (w_crc_ld)
    );

    crc16_serial u_crc_rb (
        .clk (prog_clk),
        .rst (prog_rst),
        .clr (w_start_acc),
        .en  (w_rb_en),
        .d   (prog_ret),
        .crc (w_crc_rb)
    );

    assign busy  = (r_state == ST_LOAD) | (r_state == ST_CHECK);
    assign done  = (r_state == ST_DONE);
    assign error = VERIFY & (r_state == ST_DONE) & (w_crc_rb != w_crc_ld);
    assign crc   = w_crc_ld;

endmodule
`default_nettype wire

// File: tb/tb_config_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_config_loader
// Brief   : Scoreboard bench: an 80-bit VERIFY=1 loader and a 20-bit VERIFY=0
//           loader, each driving a behavioural shift-register chain model.
// Revision: 1.0  initial release
// ============================================================================
module tb_config_loader;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [79:0] chain;
        logic [15:0] crc;
        logic        err;
        int          hs;
        int          en_cycles;
        bit          contig;
        bit          chk_chain;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  st;
    logic [7:0]  s_data;
    logic        s_valid;
    logic [1:0]  rdy, pd, pe, pr, bsy, dn, er;
    logic [15:0] cr0, cr1;

    logic [79:0] ch0 = '0;
    logic [79:0] ch1 = '0;
    bit          stuck = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    config_loader #(.CHAIN_LEN(80), .VERIFY(1'b1)) u_dut80 (
        .prog_clk(clk), .prog_rst(rst), .start(st[0]), .s_data(s_data),
        .s_valid(s_valid), .s_ready(rdy[0]), .prog_data(pd[0]), .prog_en(pe[0]),
        .prog_ret(pr[0]), .busy(bsy[0]), .done(dn[0]), .error(er[0]), .crc(cr0)
    );

    config_loader #(.CHAIN_LEN(20), .VERIFY(1'b0)) u_dut20 (
        .prog_clk(clk), .prog_rst(rst), .start(st[1]), .s_data(s_data),
        .s_valid(s_valid), .s_ready(rdy[1]), .prog_data(pd[1]), .prog_en(pe[1]),
        .prog_ret(pr[1]), .busy(bsy[1]), .done(dn[1]), .error(er[1]), .crc(cr1)
    );

    // Chain models: bit 0 is the tail; new bits enter at the head.
    always @(posedge clk) begin : chain_model
        logic [79:0] n;
        if (pe[0]) begin
            n = {pd[0], ch0[79:1]};
            if (stuck) n[40] = 1'b0;
            ch0 <= n;
        end
        if (pe[1]) ch1 <= {60'd0, pd[1], ch1[19:1]};
    end
    assign pr[0] = ch0[0];
    assign pr[1] = ch1[0];

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tfail(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got timeout expected event", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_crc(input logic [79:0] bits, input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            fb = bits[k] ^ c[15];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    // Scoreboard monitor: one expectation popped per rising done.
    int   hs_c[2], en_c[2], first_en[2], last_en[2];
    bit   dn_prev[2];
    exp_t me;

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rst || (st[d] && !bsy[d])) begin
                hs_c[d] = 0; en_c[d] = 0; first_en[d] = -1; last_en[d] = -1;
            end else begin
                if (s_valid && rdy[d]) hs_c[d]++;
                if (pe[d]) begin
                    en_c[d]++;
                    if (first_en[d] < 0) first_en[d] = cyc;
                    last_en[d] = cyc;
                end
            end
            if (dn[d] && !dn_prev[d]) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    chk($sformatf("unexpected done d%0d", d), 1, 0);
                end else begin
                    me = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("crc d%0d", d), (d == 0) ? cr0 : cr1, me.crc);
                    chk($sformatf("error d%0d", d), er[d], me.err);
                    chk($sformatf("handshakes d%0d", d), hs_c[d], me.hs);
                    chk($sformatf("prog_en cycles d%0d", d), en_c[d], me.en_cycles);
                    chk($sformatf("done latency d%0d", d), cyc, last_en[d] + 1);
                    if (me.contig)
                        chk($sformatf("prog_en contiguous d%0d", d), last_en[d] - first_en[d] + 1, en_c[d]);
                    if (me.chk_chain)
                        chk($sformatf("chain d%0d", d), (d == 0) ? ch0 : ch1, me.chain);
                end
            end
            dn_prev[d] = dn[d];
        end
    end

    task automatic run(input int d, input bq_t bytes, input int gap, input bit stk, input bit poke);
        exp_t        e;
        int          len, nb, t;
        logic [7:0]  b;
        len = (d == 0) ? 80 : 20;
        nb  = (len + 7) / 8;
        e.chain = '0;
        for (int k = 0; k < len; k++) begin
            b = bytes[k / 8];
            e.chain[k] = b[k % 8];
        end
        e.crc       = ref_crc(e.chain, len);
        e.err       = stk;
        e.hs        = nb;
        e.en_cycles = (d == 0) ? 2 * len : len;
        e.contig    = (gap == 0);
        e.chk_chain = !stk;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        stuck = stk;

        st[d] = 1'b1;
        tick();
        st = '0;
        for (int i = 0; i < nb; i++) begin
            s_data  = bytes[i];
            s_valid = 1'b1;
            if (poke && i == 2) st[d] = 1'b1;
            t = 0;
            while (!rdy[d] && t < 300) begin tick(); st = '0; t++; end
            if (!rdy[d]) begin
                tfail("ready wait");
                s_valid = 1'b0; st = '0;
                q0.delete(); q1.delete();
                return;
            end
            tick();
            st = '0;
            if (poke && i == 2) chk("busy after LOAD start", bsy[d], 1);
            if (gap > 0 && i < nb - 1) begin
                s_valid = 1'b0;
                t = 0;
                while (!(rdy[d] && !pe[d]) && t < 300) begin tick(); t++; end
                repeat (gap) begin chk("prog_en in stall", pe[d], 0); tick(); end
            end
        end
        s_valid = 1'b0;
        if (poke && d == 0) begin
            repeat (40) tick();
            st[0] = 1'b1;
            tick();
            st = '0;
            chk("busy after CHECK start", bsy[0], 1);
            chk("done after CHECK start", dn[0], 0);
        end
        t = 0;
        while (!dn[d] && t < 500) begin tick(); t++; end
        if (!dn[d]) begin
            tfail("done wait");
            q0.delete(); q1.delete();
        end
        tick(); tick();
        stuck = 1'b0;
    endtask

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bq_t t1, tff;
        int  n, i, t;
        bit  acc;
        rst = 1'b1; st = '0; s_data = '0; s_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst s_ready",   rdy[0], 0);
        chk("rst prog_en",   pe[0], 0);
        chk("rst prog_data", pd[0], 0);
        chk("rst busy",      bsy[0], 0);
        chk("rst done",      dn[0], 0);
        chk("rst error",     er[0], 0);
        chk("rst crc",       cr0, 16'hFFFF);
        chk("rst done d1",   dn[1], 0);

        for (int k = 0; k < 10; k++) t1.push_back(8'(k));
        for (int k = 0; k < 10; k++) tff.push_back(8'hFF);

        run(0, t1, 0, 0, 0);                                   // ascending bytes
        run(1, '{8'hA5, 8'h3C, 8'hFF}, 0, 0, 0);               // short chain
        chk("short chain image", ch1[19:0], 20'hF3CA5);
        run(0, tff, 0, 1, 0);                                  // stuck tap
        run(0, t1, 5, 0, 0);                                   // host stalls

        // Reset in the middle of LOAD while bit 37 is shifted.
        st[0] = 1'b1; tick(); st = '0;
        i = 0; n = 0; t = 0;
        s_data = t1[0]; s_valid = 1'b1;
        while (t < 500) begin
            acc = s_valid & rdy[0];
            if (pe[0]) begin
                if (n == 37) begin rst = 1'b1; break; end
                n++;
            end
            tick(); t++;
            if (acc) begin
                i++;
                if (i < 10) s_data = t1[i]; else s_valid = 1'b0;
            end
        end
        if (!rst) tfail("reset point");
        s_valid = 1'b0;
        tick();
        chk("midrst s_ready",   rdy[0], 0);
        chk("midrst prog_en",   pe[0], 0);
        chk("midrst prog_data", pd[0], 0);
        chk("midrst busy",      bsy[0], 0);
        chk("midrst done",      dn[0], 0);
        chk("midrst error",     er[0], 0);
        chk("midrst crc",       cr0, 16'hFFFF);
        rst = 1'b0;
        tick();
        run(0, t1, 0, 0, 0);

        run(0, rand_bytes(10), 0, 0, 1);                       // ignored starts
        run(1, rand_bytes(3), 0, 0, 1);
        for (int r = 0; r < 4; r++) begin
            run(0, rand_bytes(10), (r % 2) * 3, 0, 0);
            run(1, rand_bytes(3), (r % 2) * 2, 0, 0);
        end

        chk("scoreboard drained d0", q0.size(), 0);
        chk("scoreboard drained d1", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
